// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and constants for the branch predictor
//                (2-bit direction counter encoding, sequential PC step).
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // 2-bit saturating direction counter; bit 1 is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Byte distance to the sequential next instruction
    localparam int PcStep = 4;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter2
//  Description : Next-state logic for a 2-bit saturating direction counter.
//                force_st pins the counter to strongly-taken (jumps).
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_e state,
    input  logic taken,
    input  logic force_st,
    output ctr_e next_state
);

    // Saturating step toward the resolved direction, overridden by force_st
    always_comb begin
        next_state = state;
        if (force_st) begin
            next_state = ST;
        end else if (taken) begin
            if (state != ST) begin
                next_state = ctr_e'(state + 2'b01);
            end
        end else begin
            if (state != SNT) begin
                next_state = ctr_e'(state - 2'b01);
            end
        end
    end

endmodule : sat_counter2
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped BTB with 2-bit direction counters. Lookup is
//                combinational on the fetch PC; updates from the resolve stage
//                train the table and raise a registered redirect on
//                mispredicts. Saturating branch/mispredict statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int AddressWidth = 10,
    parameter int Entries      = 16,
    parameter int StatWidth    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [AddressWidth-1:0] fetch_pc_i,
    output logic                    pred_taken_o,
    output logic [AddressWidth-1:0] pred_target_o,
    input  logic                    upd_valid_i,
    input  logic [AddressWidth-1:0] upd_pc_i,
    input  logic                    upd_jump_i,
    input  logic                    upd_taken_i,
    input  logic [AddressWidth-1:0] upd_target_i,
    input  logic                    upd_pred_taken_i,
    input  logic [AddressWidth-1:0] upd_pred_target_i,
    output logic                    mispredict_o,
    output logic [AddressWidth-1:0] redirect_pc_o,
    output logic [StatWidth-1:0]    stat_branches_o,
    output logic [StatWidth-1:0]    stat_mispredicts_o
);

    localparam int IdxW = $clog2(Entries);
    localparam int TagW = AddressWidth - IdxW - 2;

    localparam logic [AddressWidth-1:0] C_PC_STEP  = AddressWidth'(PcStep);
    localparam logic [StatWidth-1:0]    C_STAT_ONE = StatWidth'(1);

    // Table storage: flop arrays so every entry clears on reset
    logic                    r_valid  [Entries];
    logic [TagW-1:0]         r_tag    [Entries];
    logic [AddressWidth-1:0] r_target [Entries];
    ctr_e                    r_ctr    [Entries];

    logic                    r_mispredict;
    logic [AddressWidth-1:0] r_redirect_pc;
    logic [StatWidth-1:0]    r_stat_branches;
    logic [StatWidth-1:0]    r_stat_mispredicts;

    // ---------------- Fetch-side lookup ----------------
    logic [IdxW-1:0] w_fetch_idx;
    logic [TagW-1:0] w_fetch_tag;
    logic            w_fetch_hit;
    ctr_e            w_fetch_ctr;

    assign w_fetch_idx = fetch_pc_i[IdxW+1:2];
    assign w_fetch_tag = fetch_pc_i[AddressWidth-1:IdxW+2];
    assign w_fetch_ctr = r_ctr[w_fetch_idx];
    assign w_fetch_hit = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);

    assign pred_taken_o  = w_fetch_hit & w_fetch_ctr[1];
    assign pred_target_o = pred_taken_o ? r_target[w_fetch_idx] : (fetch_pc_i + C_PC_STEP);

    // ---------------- Update-side decode ----------------
    logic [IdxW-1:0]         w_upd_idx;
    logic [TagW-1:0]         w_upd_tag;
    logic                    w_upd_hit;
    logic                    w_eff_taken;
    logic                    w_upd_write;
    ctr_e                    w_ctr_cur;
    ctr_e                    w_ctr_next;
    logic                    w_mispredict;
    logic [AddressWidth-1:0] w_redirect_pc;

    assign w_upd_idx = upd_pc_i[IdxW+1:2];
    assign w_upd_tag = upd_pc_i[AddressWidth-1:IdxW+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    // Jumps always redirect, so they train the table as taken
    assign w_eff_taken = upd_taken_i | upd_jump_i;

    // Hits always train; misses only allocate when taken
    assign w_upd_write = upd_valid_i & (w_upd_hit | w_eff_taken);

    // A fresh allocation starts from WNT so one taken step lands on WT
    assign w_ctr_cur = w_upd_hit ? r_ctr[w_upd_idx] : WNT;

    sat_counter2 u_sat_counter2 (
        .state      (w_ctr_cur),
        .taken      (w_eff_taken),
        .force_st   (upd_jump_i),
        .next_state (w_ctr_next)
    );

    assign w_mispredict = upd_valid_i &
                          ((upd_taken_i != upd_pred_taken_i) |
                           (upd_taken_i & (upd_target_i != upd_pred_target_i)));

    assign w_redirect_pc = upd_taken_i ? upd_target_i : (upd_pc_i + C_PC_STEP);

    // ---------------- Table entries ----------------
    for (genvar i = 0; i < Entries; i++) begin : g_entry
        // Write the selected entry on a training update; reset clears it
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= WNT;
            end else if (w_upd_write && (w_upd_idx == IdxW'(i))) begin
                r_valid[i] <= 1'b1;
                r_tag[i]   <= w_upd_tag;
                r_ctr[i]   <= w_ctr_next;
                if (w_eff_taken) begin
                    r_target[i] <= upd_target_i;
                end
            end
        end
    end

    // Redirect pulse: high for exactly the cycle after a mispredicting update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_mispredict <= w_mispredict;
            if (upd_valid_i) begin
                r_redirect_pc <= w_redirect_pc;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (upd_valid_i && (r_stat_branches != '1)) begin
                r_stat_branches <= r_stat_branches + C_STAT_ONE;
            end
            if (w_mispredict && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + C_STAT_ONE;
            end
        end
    end

    assign mispredict_o       = r_mispredict;
    assign redirect_pc_o      = r_redirect_pc;
    assign stat_branches_o    = r_stat_branches;
    assign stat_mispredicts_o = r_stat_mispredicts;

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed self-checking bench for branch_predictor. A second
//                instance with 2-bit statistics shares all inputs so counter
//                saturation can be observed alongside the default build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic [AW-1:0] fetch_pc;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_jump;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic [AW-1:0] upd_pred_target;

    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          mispredict;
    logic [AW-1:0] redirect_pc;
    logic [15:0]   stat_br;
    logic [15:0]   stat_mis;

    logic          s_pred_taken;
    logic [AW-1:0] s_pred_target;
    logic          s_mispredict;
    logic [AW-1:0] s_redirect_pc;
    logic [1:0]    s_stat_br;
    logic [1:0]    s_stat_mis;

    int n_assert = 0;
    int n_fail   = 0;

    branch_predictor #(.AddressWidth(AW), .Entries(16), .StatWidth(16)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .fetch_pc_i         (fetch_pc),
        .pred_taken_o       (pred_taken),
        .pred_target_o      (pred_target),
        .upd_valid_i        (upd_valid),
        .upd_pc_i           (upd_pc),
        .upd_jump_i         (upd_jump),
        .upd_taken_i        (upd_taken),
        .upd_target_i       (upd_target),
        .upd_pred_taken_i   (upd_pred_taken),
        .upd_pred_target_i  (upd_pred_target),
        .mispredict_o       (mispredict),
        .redirect_pc_o      (redirect_pc),
        .stat_branches_o    (stat_br),
        .stat_mispredicts_o (stat_mis)
    );

    branch_predictor #(.AddressWidth(AW), .Entries(16), .StatWidth(2)) dut_small (
        .clk_i              (clk),
        .rst_i              (rst),
        .fetch_pc_i         (fetch_pc),
        .pred_taken_o       (s_pred_taken),
        .pred_target_o      (s_pred_target),
        .upd_valid_i        (upd_valid),
        .upd_pc_i           (upd_pc),
        .upd_jump_i         (upd_jump),
        .upd_taken_i        (upd_taken),
        .upd_target_i       (upd_target),
        .upd_pred_taken_i   (upd_pred_taken),
        .upd_pred_target_i  (upd_pred_target),
        .mispredict_o       (s_mispredict),
        .redirect_pc_o      (s_redirect_pc),
        .stat_branches_o    (s_stat_br),
        .stat_mispredicts_o (s_stat_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Look up a PC and compare the combinational prediction
    task automatic look(input string tag, input logic [AW-1:0] pc,
                        input logic exp_taken, input logic [AW-1:0] exp_target);
        fetch_pc = pc;
        #1;
        check({tag, "_taken"},  {31'd0, pred_taken}, {31'd0, exp_taken});
        check({tag, "_target"}, {22'd0, pred_target}, {22'd0, exp_target});
    endtask

    // One update cycle; returns 1 ns after the capturing edge with valid dropped
    task automatic upd(input logic [AW-1:0] pc, input logic jump, input logic taken,
                       input logic [AW-1:0] target, input logic ptaken,
                       input logic [AW-1:0] ptarget);
        upd_pc          = pc;
        upd_jump        = jump;
        upd_taken       = taken;
        upd_target      = target;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptarget;
        upd_valid       = 1'b1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic check_redirect(input string tag, input logic exp_mis,
                                  input logic [AW-1:0] exp_pc);
        check({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, exp_mis});
        if (exp_mis) begin
            check({tag, "_redirect"}, {22'd0, redirect_pc}, {22'd0, exp_pc});
        end
    endtask

    initial begin
        rst             = 1'b1;
        fetch_pc        = '0;
        upd_valid       = 1'b0;
        upd_pc          = '0;
        upd_jump        = 1'b0;
        upd_taken       = 1'b0;
        upd_target      = '0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        look("reset_lookup", 10'h040, 1'b0, 10'h044);
        check("reset_mispredict", {31'd0, mispredict}, 32'd0);
        check("reset_redirect", {22'd0, redirect_pc}, 32'd0);
        check("reset_stat_br", {16'd0, stat_br}, 32'd0);
        check("reset_stat_mis", {16'd0, stat_mis}, 32'd0);

        // Allocate 0x040 taken -> WT, mispredicted as not-taken
        upd(10'h040, 1'b0, 1'b1, 10'h100, 1'b0, 10'h044);
        check_redirect("alloc", 1'b1, 10'h100);
        look("alloc_lookup", 10'h040, 1'b1, 10'h100);
        @(posedge clk); #1;
        check("alloc_pulse_one_cycle", {31'd0, mispredict}, 32'd0);

        // Correctly predicted taken: WT -> ST, no redirect
        upd(10'h040, 1'b0, 1'b1, 10'h100, 1'b1, 10'h100);
        check_redirect("correct", 1'b0, 10'h000);
        check("stat_br_2", {16'd0, stat_br}, 32'd2);
        check("stat_mis_1", {16'd0, stat_mis}, 32'd1);

        // Five not-taken updates from ST: WT, WNT, SNT, SNT, SNT
        for (int k = 1; k <= 5; k++) begin
            upd(10'h040, 1'b0, 1'b0, 10'h100, 1'b0, 10'h044);
            if (k == 1) look("nt_step", 10'h040, 1'b1, 10'h100);
            else        look("nt_step", 10'h040, 1'b0, 10'h044);
        end
        check("nt_no_mispredict", {31'd0, mispredict}, 32'd0);

        // From SNT one taken only reaches WNT; target is still rewritten
        upd(10'h040, 1'b0, 1'b1, 10'h140, 1'b0, 10'h044);
        check_redirect("snt_up", 1'b1, 10'h140);
        look("snt_up_lookup", 10'h040, 1'b0, 10'h044);
        upd(10'h040, 1'b0, 1'b1, 10'h140, 1'b0, 10'h044);
        look("wnt_up_lookup", 10'h040, 1'b1, 10'h140);

        // Alias: 0x080 shares index 0 with 0x040 and replaces it
        upd(10'h080, 1'b0, 1'b1, 10'h200, 1'b0, 10'h084);
        look("alias_old", 10'h040, 1'b0, 10'h044);
        look("alias_new", 10'h080, 1'b1, 10'h200);

        // Direction right but target wrong still mispredicts
        upd(10'h080, 1'b0, 1'b1, 10'h200, 1'b1, 10'h204);
        check_redirect("target_mis", 1'b1, 10'h200);

        // Jump allocates straight to ST: one not-taken leaves it predicting taken
        upd(10'h010, 1'b1, 1'b1, 10'h300, 1'b0, 10'h014);
        look("jump_lookup", 10'h010, 1'b1, 10'h300);
        upd(10'h010, 1'b0, 1'b0, 10'h300, 1'b1, 10'h300);
        check_redirect("jump_nt", 1'b1, 10'h014);
        look("jump_after_nt", 10'h010, 1'b1, 10'h300);

        // Same-cycle lookup and allocate at 0x3FC: old contents, wrapping +4
        fetch_pc        = 10'h3FC;
        upd_pc          = 10'h3FC;
        upd_jump        = 1'b0;
        upd_taken       = 1'b1;
        upd_target      = 10'h120;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 10'h000;
        upd_valid       = 1'b1;
        #1;
        check("same_cycle_taken", {31'd0, pred_taken}, 32'd0);
        check("same_cycle_target", {22'd0, pred_target}, 32'h000);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        look("same_cycle_next", 10'h3FC, 1'b1, 10'h120);

        // Not-taken redirect wraps to pc+4
        upd(10'h3FC, 1'b0, 1'b0, 10'h120, 1'b1, 10'h120);
        check_redirect("wrap_redirect", 1'b1, 10'h000);
        check("stats_br_15", {16'd0, stat_br}, 32'd15);
        check("stats_mis_9", {16'd0, stat_mis}, 32'd9);
        check("small_br_sat", {30'd0, s_stat_br}, 32'd3);

        // Reset asserted mid-update: asynchronous clear, update discarded
        upd_pc          = 10'h3FC;
        upd_taken       = 1'b1;
        upd_target      = 10'h150;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 10'h000;
        upd_valid       = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_stat_br", {16'd0, stat_br}, 32'd0);
        check("async_rst_redirect", {22'd0, redirect_pc}, 32'd0);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        rst = 1'b0;
        look("post_rst_lookup", 10'h3FC, 1'b0, 10'h000);
        check("post_rst_mispredict", {31'd0, mispredict}, 32'd0);

        // Five mispredicting updates: 16-bit stats count, 2-bit stats saturate
        for (int k = 0; k < 5; k++) begin
            upd(AW'(10'h020 + 10'(k * 4)), 1'b0, 1'b1, 10'h200, 1'b0, 10'h000);
        end
        check("sat_main_br", {16'd0, stat_br}, 32'd5);
        check("sat_main_mis", {16'd0, stat_mis}, 32'd5);
        check("sat_small_br", {30'd0, s_stat_br}, 32'd3);
        check("sat_small_mis", {30'd0, s_stat_mis}, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL provide parameter AddressWidth, default 10, meaning PC width in bits (byte address).
REQ-002 The block SHALL provide parameter Entries, default 16, meaning number of BTB/counter entries (power of 2, 2..256).
REQ-003 The block SHALL provide parameter StatWidth, default 16, meaning width of each performance counter.
REQ-004 clk_i  input  1  sole clock, rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 fetch_pc_i  input  AddressWidth  PC being fetched.
REQ-007 pred_taken_o  output  1  predicted taken for fetch_pc_i.
REQ-008 pred_target_o  output  AddressWidth  predicted next PC.
REQ-009 upd_valid_i  input  1  resolved control-flow instruction present.
REQ-010 upd_pc_i  input  AddressWidth  PC of resolved instruction.
REQ-011 upd_jump_i  input  1  resolved instruction is jal/jalr (unconditional).
REQ-012 upd_taken_i  input  1  actual direction.
REQ-013 upd_target_i  input  AddressWidth  actual target.
REQ-014 upd_pred_taken_i / upd_pred_target_i  input  1 / AddressWidth  prediction made at fetch for that instruction.
REQ-015 mispredict_o  output  1  registered redirect request.
REQ-016 redirect_pc_o  output  AddressWidth  registered correct next PC.
REQ-017 stat_branches_o / stat_mispredicts_o  output  StatWidth each  performance counters.

Function
REQ-018 Index SHALL be pc[IdxW+1:2], IdxW=log2(Entries); tag SHALL be pc[AddressWidth-1:IdxW+2].
REQ-019 Each entry SHALL hold valid, tag, target (AddressWidth) and 2-bit counter: SNT=00, WNT=01, WT=10, ST=11.
REQ-020 Lookup SHALL be combinational: hit = valid & tag match; pred_taken_o = hit & counter[1].
REQ-021 pred_target_o SHALL be entry target when pred_taken_o, else fetch_pc_i+4 truncated to AddressWidth (wraps).
REQ-022 Update SHALL occur on rising edge when upd_valid_i; no table change otherwise.
REQ-023 Update hit, conditional branch: counter SHALL saturate-increment if taken, saturate-decrement if not (ST stays ST, SNT stays SNT).
REQ-024 Update hit, taken: target SHALL be overwritten with upd_target_i; not-taken leaves target unchanged.
REQ-025 Update miss, taken: entry SHALL be allocated (replacing any occupant): valid=1, new tag, target, counter WT.
REQ-026 Update miss, not taken: no allocation.
REQ-027 Jump (upd_jump_i=1): counter SHALL be forced to ST regardless of hit.
REQ-028 Mispredict = upd_valid_i & (upd_taken_i != upd_pred_taken_i | (upd_taken_i & upd_target_i != upd_pred_target_i)).
REQ-029 mispredict_o SHALL assert exactly one cycle after the update cycle, for one cycle; redirect_pc_o SHALL be upd_target_i if taken, else upd_pc_i+4, registered in the same edge.
REQ-030 Lookup and update to the same index in one cycle: lookup SHALL return pre-update contents; new contents visible next cycle.
REQ-031 stat_branches_o SHALL increment per upd_valid_i; stat_mispredicts_o per mispredict; both saturate at all-ones.

Reset
REQ-032 On rst_i assertion all valid bits SHALL clear, counters SHALL become WNT, mispredict_o=0, redirect_pc_o=0, stats=0, asynchronously.
REQ-033 Reset mid-update SHALL discard the update; first post-reset lookup SHALL predict not-taken, target fetch_pc_i+4.

Structure
REQ-034 Package bp_pkg SHALL hold counter enum (SNT/WNT/WT/ST) and constant PcStep=4.
REQ-035 Sub-module sat_counter2 SHALL implement 2-bit saturating next-state (inputs: state, taken, force_st).
REQ-036 Tables SHALL be flop arrays (async reset required; no RAM inference).

Verification
REQ-037 Reset, fetch_pc_i=0x040 -> pred_taken_o=0, pred_target_o=0x044.
REQ-038 Update pc=0x040 taken target=0x100, pred_taken=0 -> next cycle mispredict_o=1, redirect_pc_o=0x100; lookup 0x040 -> taken, 0x100 (WT).
REQ-039 Four not-taken updates at 0x040 from ST -> counter SNT, stays SNT on fifth; prediction not-taken after second.
REQ-040 Alias: 0x040 allocated, then taken update 0x080 (same index, Entries=16) -> 0x040 misses, 0x080 hits.
REQ-041 Same-cycle lookup and allocate at 0x3FC -> old prediction (not-taken, target 0x000 wrap), new next cycle.
REQ-042 StatWidth=2, five mispredicting updates -> both stats hold 3.
